regfile_writeback_queue: RTL and testbench

- Writer-side companion to the register file: collects writeback requests from the ALU and load/store paths and drives the register file's single write port (reg_write_en/addr/data).
- Requests are buffered in a small FIFO and retired one per cycle through a registered output stage.
- Exposes a pending-write check so decode can stall on read-after-write hazards against queued writes.

---
 rtl/regfile_writeback_queue.sv | 127 ++++++++++++
 tb/tb_regfile_writeback_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_queue.sv
// Writeback queue: merges ALU and load writebacks into the register file's single write port.
// Optional WB_FORWARD_EN adds youngest-match data forwarding on the hazard-check outputs.
module regfile_writeback_queue #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_wb_valid,
  output logic                          alu_wb_ready,
  input  logic [ADDR_W-1:0]             alu_wb_addr,
  input  logic [DATA_W-1:0]             alu_wb_data,
  input  logic                          mem_wb_valid,
  output logic                          mem_wb_ready,
  input  logic [ADDR_W-1:0]             mem_wb_addr,
  input  logic [DATA_W-1:0]             mem_wb_data,
  output logic                          reg_write_en,
  output logic [ADDR_W-1:0]             reg_write_addr,
  output logic [DATA_W-1:0]             reg_write_data,
  input  logic [ADDR_W-1:0]             chk_addr_1,
  input  logic [ADDR_W-1:0]             chk_addr_2,
  output logic                          chk_busy_1,
  output logic                          chk_busy_2,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef WB_FORWARD_EN
  ,
  output logic [DATA_W-1:0]             chk_fwd_data_1,
  output logic [DATA_W-1:0]             chk_fwd_data_2
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              not_full, push_fire, push, pop;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;

  assign not_full     = count < CNT_W'(FIFO_DEPTH);
  assign mem_wb_ready = not_full;
  assign alu_wb_ready = not_full & ~mem_wb_valid;
  assign push_fire    = (mem_wb_valid & mem_wb_ready) | (alu_wb_valid & alu_wb_ready);
  assign push_addr    = mem_wb_valid ? mem_wb_addr : alu_wb_addr;
  assign push_data    = mem_wb_valid ? mem_wb_data : alu_wb_data;
  // x0 writes finish the handshake but are dropped here
  assign push         = push_fire && (push_addr != '0);
  assign pop          = count != '0;
  assign fifo_count   = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count          <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      reg_write_en   <= 1'b0;
      reg_write_addr <= '0;
      reg_write_data <= '0;
    end else begin
      if (push) begin
        addr_mem[wr_ptr] <= push_addr;
        data_mem[wr_ptr] <= push_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        reg_write_addr <= addr_mem[rd_ptr];
        reg_write_data <= data_mem[rd_ptr];
        rd_ptr         <= rd_ptr + 1'b1;
      end
      reg_write_en <= pop;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  logic [ADDR_W-1:0] chk_addr [2];
  logic              busy     [2];
  assign chk_addr[0] = chk_addr_1;
  assign chk_addr[1] = chk_addr_2;
  assign chk_busy_1  = busy[0];
  assign chk_busy_2  = busy[1];

`ifdef WB_FORWARD_EN
  logic [DATA_W-1:0] fwd [2];
  assign chk_fwd_data_1 = fwd[0];
  assign chk_fwd_data_2 = fwd[1];
`endif

  // Scan oldest to youngest so the last hit left standing is the youngest match
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      busy[c] = 1'b0;
`ifdef WB_FORWARD_EN
      fwd[c]  = '0;
`endif
      if (reg_write_en && reg_write_addr == chk_addr[c]) begin
        busy[c] = 1'b1;
`ifdef WB_FORWARD_EN
        fwd[c]  = reg_write_data;
`endif
      end
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        if (CNT_W'(k) < count && addr_mem[rd_ptr + PTR_W'(k)] == chk_addr[c]) begin
          busy[c] = 1'b1;
`ifdef WB_FORWARD_EN
          fwd[c]  = data_mem[rd_ptr + PTR_W'(k)];
`endif
        end
      end
      if (chk_addr[c] == '0) begin
        busy[c] = 1'b0;
`ifdef WB_FORWARD_EN
        fwd[c]  = '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scoreboard bench for regfile_writeback_queue: expected writes are queued at acceptance,
// a negedge monitor retires them against reg_write_*.
module tb_regfile_writeback_queue;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic reset;
  logic alu_wb_valid, alu_wb_ready, mem_wb_valid, mem_wb_ready;
  logic [AW-1:0] alu_wb_addr, mem_wb_addr, reg_write_addr, chk_addr_1, chk_addr_2;
  logic [DW-1:0] alu_wb_data, mem_wb_data, reg_write_data;
  logic reg_write_en, chk_busy_1, chk_busy_2;
  logic [$clog2(D):0] fifo_count;
`ifdef WB_FORWARD_EN
  logic [DW-1:0] chk_fwd_data_1, chk_fwd_data_2;
`endif

  int total = 0;
  int bad   = 0;
  logic [AW+DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_writeback_queue #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
    .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
    .mem_wb_valid(mem_wb_valid), .mem_wb_ready(mem_wb_ready),
    .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data),
    .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data),
    .chk_addr_1(chk_addr_1), .chk_addr_2(chk_addr_2),
    .chk_busy_1(chk_busy_1), .chk_busy_2(chk_busy_2),
    .fifo_count(fifo_count)
`ifdef WB_FORWARD_EN
    , .chk_fwd_data_1(chk_fwd_data_1), .chk_fwd_data_2(chk_fwd_data_2)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every issued write must match the oldest expected one
  always @(negedge clk) begin
    if (reg_write_en === 1'b1) begin
      logic [AW+DW-1:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write actual=%0h:%0h required=none", reg_write_addr, reg_write_data);
      end else begin
        e = exp_q.pop_front();
        if ({reg_write_addr, reg_write_data} !== e) begin
          bad++;
          $display("FAIL retire actual=%0h:%0h required=%0h:%0h",
                   reg_write_addr, reg_write_data, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request, wait (bounded) for ready, complete handshake; returns 1 time unit after the edge
  task automatic push_one(input bit is_mem, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_retire);
    int n = 0;
    if (is_mem) begin
      mem_wb_valid = 1'b1; mem_wb_addr = a; mem_wb_data = d;
    end else begin
      alu_wb_valid = 1'b1; alu_wb_addr = a; alu_wb_data = d;
    end
    #1;
    while (!(is_mem ? mem_wb_ready : alu_wb_ready) && n < 20) begin
      @(posedge clk); #2; n++;
    end
    chk(is_mem ? "mem_ready" : "alu_ready", is_mem ? mem_wb_ready : alu_wb_ready, 1);
    if (expect_retire && a != '0) exp_q.push_back({a, d});
    @(posedge clk);
    #1;
    mem_wb_valid = 1'b0;
    alu_wb_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    alu_wb_valid = 1'b0; alu_wb_addr = '0; alu_wb_data = '0;
    mem_wb_valid = 1'b0; mem_wb_addr = '0; mem_wb_data = '0;
    chk_addr_1 = '0; chk_addr_2 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_count", fifo_count, 0);
    chk("rst_en", reg_write_en, 0);
    chk("rst_addr", reg_write_addr, 0);
    chk("rst_data", reg_write_data, 0);

    // single ALU write
    push_one(0, 5'd5, 32'hDEADBEEF, 1);
    chk("t1_count1", fifo_count, 1);
    chk("t1_en_pre", reg_write_en, 0);
    step();
    chk("t1_count0", fifo_count, 0);
    chk("t1_en", reg_write_en, 1);
    step();
    chk("t1_en_off", reg_write_en, 0);
    chk("t1_addr_hold", reg_write_addr, 5);

    // both sources: mem wins, ALU next cycle
    mem_wb_valid = 1'b1; mem_wb_addr = 5'd3; mem_wb_data = 32'h11;
    alu_wb_valid = 1'b1; alu_wb_addr = 5'd4; alu_wb_data = 32'h22;
    #1;
    chk("t2_mem_ready", mem_wb_ready, 1);
    chk("t2_alu_blocked", alu_wb_ready, 0);
    exp_q.push_back({5'd3, 32'h11});
    @(posedge clk); #1;
    mem_wb_valid = 1'b0;
    #1;
    chk("t2_alu_ready", alu_wb_ready, 1);
    exp_q.push_back({5'd4, 32'h22});
    @(posedge clk); #1;
    alu_wb_valid = 1'b0;
    chk("t2_first_en", reg_write_en, 1);
    chk("t2_first_addr", reg_write_addr, 3);
    step();
    chk("t2_second_en", reg_write_en, 1);
    chk("t2_second_addr", reg_write_addr, 4);
    step();

    // six back-to-back ALU requests
    for (int i = 0; i < 6; i++) push_one(0, AW'(10 + i), DW'(32'h100 + i), 1);
    repeat (4) step();
    chk("t3_count_drained", fifo_count, 0);
    chk("t3_all_retired", exp_q.size(), 0);

    // x0 write is dropped
    push_one(0, 5'd0, 32'h1234, 1);
    chk("t4_count", fifo_count, 0);
    repeat (3) begin
      step();
      chk("t4_no_write", reg_write_en, 0);
    end

    // hazard check on x7
    chk_addr_1 = 5'd7; chk_addr_2 = 5'd0;
    push_one(0, 5'd7, 32'hA, 1);
    #1;
    chk("t5_busy1_a", chk_busy_1, 1);
    chk("t5_busy2_a", chk_busy_2, 0);
    push_one(0, 5'd7, 32'hB, 1);
    #1;
    chk("t5_busy1_b", chk_busy_1, 1);
    chk("t5_busy2_b", chk_busy_2, 0);
`ifdef WB_FORWARD_EN
    chk("t5_fwd_young", chk_fwd_data_1, 32'hB);
    chk("t5_fwd2_zero", chk_fwd_data_2, 0);
`endif
    step();
    chk("t5_busy1_out", chk_busy_1, 1);
`ifdef WB_FORWARD_EN
    chk("t5_fwd_out", chk_fwd_data_1, 32'hB);
`endif
    step();
    chk("t5_busy1_clear", chk_busy_1, 0);
    chk("t5_busy2_clear", chk_busy_2, 0);

    // reset mid-operation: x3 still queued must never be written
    chk_addr_1 = 5'd3; chk_addr_2 = 5'd2;
    push_one(1, 5'd1, 32'h31, 1);
    push_one(1, 5'd2, 32'h32, 1);
    push_one(1, 5'd3, 32'h33, 0);
    chk("t6_pre_count", fifo_count, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("t6_count", fifo_count, 0);
    chk("t6_en", reg_write_en, 0);
    chk("t6_busy1", chk_busy_1, 0);
    chk("t6_busy2", chk_busy_2, 0);
    repeat (5) begin
      step();
      chk("t6_no_write", reg_write_en, 0);
    end
    chk("t6_scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
